// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters for the fetch stage.
// Lookup is combinational; resolved branches from EX update the array on the rising edge.
module branch_predictor #(
   parameter int unsigned ENTRIES  = 16,
   parameter logic [1:0]  CTR_INIT = 2'd2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [31:0]      fetch_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             upd_en,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_pred_taken,
   input  logic [31:0]      upd_pred_target,
   output logic             mispredict,
   input  logic             clear,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [TAG_W-1:0]   tag_d [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [31:0]        tgt_d [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];
   logic [1:0]         ctr_d [ENTRIES];
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [IDX_W-1:0]   f_idx, u_idx;
   logic [TAG_W-1:0]   f_tag, u_tag;
   logic               u_hit;
   logic               unused_pc_lsbs;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[31:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[31:IDX_W+2];
   assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

   // Lookup reads only the current array state; no bypass from a same-cycle update
   always_comb begin
      pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      pred_taken  = pred_hit && ctr_q[f_idx][1];
      pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;
   end

   assign mispredict  = upd_en && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
   assign mispred_cnt = cnt_q;
   assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   // Next-state: clear wins over update; not-taken misses leave the array alone
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      cnt_d   = cnt_q;
      if (clear) begin
         valid_d = '0;
         cnt_d   = '0;
      end else if (upd_en) begin
         if (u_hit) begin
            if (upd_taken) begin
               ctr_d[u_idx] = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
               tgt_d[u_idx] = upd_target;
            end else begin
               ctr_d[u_idx] = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_d[u_idx] = 1'b1;
            tag_d[u_idx]   = u_tag;
            tgt_d[u_idx]   = upd_target;
            ctr_d[u_idx]   = CTR_INIT;
         end
         if (mispredict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         ctr_q   <= ctr_d;
      end
   end

   // Tag and target are qualified by valid, so they need no reset
   always_ff @(posedge CLK) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
   end

endmodule
